uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Single-clock FIFO that buffers bytes for the UART transmitter and presents them on the transmitter's `F_EMPTY`/`RD_DATA` read interface. The writer side accepts bytes from the system (register file or host logic). The read side needs no explicit read-enable: entries are popped by detecting the rising edge of the transmitter's `Busy` output. It sits between the system write path and `UART_TOP` in the `TX_CLK` domain.

## Interface
- `DATA_WIDTH`, 8, byte width; must match the UART.
- `DEPTH`, 8, number of entries; power of two, at least 2. Internal `ADDR_WIDTH = $clog2(DEPTH)`.
- `TX_CLK` input 1: the only clock. All state updates on the rising edge.
- `RST` input 1: asynchronous, active-low reset.
- `WR_EN` input 1: write request, sampled on the rising edge.
- `WR_DATA` input `DATA_WIDTH`: write data.
- `BUSY` input 1: the transmitter's `Busy`; a 0→1 edge means the head entry was consumed.
- `RD_DATA` output `DATA_WIDTH`: head entry (first-word-fall-through); valid only while `F_EMPTY`=0.
- `F_EMPTY` output 1: FIFO holds 0 entries.
- `F_FULL` output 1: FIFO holds `DEPTH` entries.
- `FILL_LEVEL` output `ADDR_WIDTH+1`: current entry count, 0..`DEPTH`.
- `OVF` output 1: sticky flag; set when a write is dropped.

## Operation
- Storage:
  - `DEPTH` x `DATA_WIDTH` array.
  - `wr_ptr` and `rd_ptr` are each `ADDR_WIDTH+1` bits wide; the MSB is the wrap bit.
  - `FILL_LEVEL = wr_ptr - rd_ptr`, modulo 2^(`ADDR_WIDTH`+1).
  - `F_EMPTY` = (`wr_ptr` == `rd_ptr`).
  - `F_FULL` = (addresses equal, wrap bits differ).
- Pop detect:
  - `busy_q` register captures `BUSY` every cycle.
  - `pop = BUSY & ~busy_q & ~F_EMPTY`.
  - On the edge where `pop` is true, `rd_ptr` increments.
  - `BUSY` held high does not pop again.
  - A rising edge of `BUSY` while empty is ignored; no underflow.
- Write:
  - `push = WR_EN & (~F_FULL | pop)`.
  - On `push`, `mem[wr_ptr]` is written with `WR_DATA` and `wr_ptr` increments.
- Full plus simultaneous pop: the write is accepted, `FILL_LEVEL` stays at `DEPTH`, and `F_FULL` stays 1.
- Empty plus `WR_EN` plus `BUSY` rising edge: the write is accepted and the pop is ignored. `FILL_LEVEL` becomes 1.
- Non-full plus push plus pop: `FILL_LEVEL` is unchanged.
- Overflow: `WR_EN` while `F_FULL`=1 with no pop drops the data and sets `OVF`=1. `OVF` stays set until reset.
- Pointer wrap: pointers wrap naturally modulo 2^(`ADDR_WIDTH`+1). Data order is preserved across any number of wraps.
- `RD_DATA = mem[rd_ptr[ADDR_WIDTH-1:0]]`, read combinationally.
- Reset (`RST`=0, any time, including mid-frame) asynchronously clears:
  - both pointers
  - `busy_q`
  - `OVF`
  - all array entries to 0.
- Reset values of outputs: `F_EMPTY`=1, `F_FULL`=0, `FILL_LEVEL`=0, `OVF`=0, `RD_DATA`=0.
- Reset takes effect immediately and is released synchronously on the next rising edge after `RST` goes high. Contents present before reset are lost.

## Timing
- Write latency: `WR_EN` sampled at edge k → `F_EMPTY` falls and `RD_DATA` shows the byte after edge k, i.e. in cycle k+1.
- Pop latency: `BUSY` rises before edge k → `rd_ptr` advances at edge k → the next entry appears on `RD_DATA` in cycle k+1.
  - The transmitter has already latched the old `RD_DATA` by the time it asserts `Busy`.
- Throughput: one write per cycle; one pop per `BUSY` rising edge. A minimum of 2 cycles between pops is imposed by the edge detector.
- Status outputs are decoded from registered pointers only, with no combinational path from `WR_EN` or `BUSY`, except `RD_DATA`, which follows the array read.

## Test plan
- Reset then idle: `RST`=0 for 2 cycles → `F_EMPTY`=1, `F_FULL`=0, `FILL_LEVEL`=0, `OVF`=0, `RD_DATA`=8'h00.
- Single byte: write 8'hA5 at edge 1 → cycle 2 shows `F_EMPTY`=0 and `RD_DATA`=8'hA5. Hold `BUSY`=1 for 10 cycles → exactly one pop, `F_EMPTY`=1.
- Fill and overflow (`DEPTH`=8):
  - Write 8'h01..8'h08 → `F_FULL`=1, `FILL_LEVEL`=8.
  - Write 8'hFF → dropped, `OVF`=1.
  - Pop 8 times → `RD_DATA` sequence is 01..08, then `F_EMPTY`=1 with `OVF` still 1.
- Full plus simultaneous pop and write of 8'h09 → `FILL_LEVEL` stays 8, `OVF`=0. Subsequent pops yield 02..09.
- Wrap order: 20 interleaved writes (8'h10..8'h23) and pops with the level kept between 1 and 7 → pop order matches write order across pointer wrap.
- Reset mid-operation: with 5 entries held and `BUSY`=1, pulse `RST` low asynchronously between edges → outputs return to reset values at once. After release, write 8'h3C → `RD_DATA`=8'h3C and `FILL_LEVEL`=1.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: single-clock byte FIFO feeding the UART transmitter.
//
// The write side accepts bytes from the system. The read side has no read
// enable: the head entry is popped on each rising edge of the transmitter's
// BUSY output. RD_DATA is first-word-fall-through.
//
// Ports:
//   TX_CLK      clock, all state updates on the rising edge
//   RST         asynchronous active-low reset
//   WR_EN       write request
//   WR_DATA     write data
//   BUSY        transmitter busy; a 0->1 edge consumes the head entry
//   RD_DATA     head entry, valid while F_EMPTY = 0
//   F_EMPTY     FIFO holds no entries
//   F_FULL      FIFO holds DEPTH entries
//   FILL_LEVEL  current entry count, 0..DEPTH
//   OVF         sticky, set when a write is dropped
module uart_tx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                       TX_CLK,
    input  logic                       RST,
    input  logic                       WR_EN,
    input  logic [DATA_WIDTH-1:0]      WR_DATA,
    input  logic                       BUSY,
    output logic [DATA_WIDTH-1:0]      RD_DATA,
    output logic                       F_EMPTY,
    output logic                       F_FULL,
    output logic [$clog2(DEPTH):0]     FILL_LEVEL,
    output logic                       OVF
);

    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] PtrOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic                  busy_q;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic empty;
    logic full;
    logic pop;
    logic push;

    // Status decoded from registered pointers only.
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    end

    // A BUSY rising edge consumes the head; ignored when nothing is held.
    // A pop frees a slot in the same cycle, so a write while full is still taken.
    always_comb begin
        pop  = BUSY & ~busy_q & ~empty;
        push = WR_EN & (~full | pop);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        if (WR_EN && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge TX_CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            busy_q   <= BUSY;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is cleared on reset so RD_DATA reads 0 afterwards.
    always_ff @(posedge TX_CLK or negedge RST) begin
        if (!RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= WR_DATA;
        end
    end

    always_comb begin
        RD_DATA    = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        F_EMPTY    = empty;
        F_FULL     = full;
        FILL_LEVEL = wr_ptr_q - rd_ptr_q;
        OVF        = ovf_q;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a vector table for the directed
// sequences plus hand-written wrap-order and asynchronous-reset sequences.
module tb_uart_tx_fifo;

    logic       TX_CLK = 1'b0;
    logic       RST = 1'b0;
    logic       WR_EN = 1'b0;
    logic [7:0] WR_DATA = 8'h00;
    logic       BUSY = 1'b0;
    logic [7:0] RD_DATA;
    logic       F_EMPTY;
    logic       F_FULL;
    logic [3:0] FILL_LEVEL;
    logic       OVF;

    int n_cmp = 0;
    int n_fail = 0;

    uart_tx_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (8)
    ) dut (
        .TX_CLK     (TX_CLK),
        .RST        (RST),
        .WR_EN      (WR_EN),
        .WR_DATA    (WR_DATA),
        .BUSY       (BUSY),
        .RD_DATA    (RD_DATA),
        .F_EMPTY    (F_EMPTY),
        .F_FULL     (F_FULL),
        .FILL_LEVEL (FILL_LEVEL),
        .OVF        (OVF)
    );

    always #5 TX_CLK = ~TX_CLK;

    typedef struct {
        bit       rst;
        bit       wr;
        bit [7:0] din;
        bit       busy;
        bit       e_empty;
        bit       e_full;
        int       e_lvl;
        bit       e_ovf;
        bit       chk_rd;
        bit [7:0] e_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit rst, bit wr, bit [7:0] din, bit busy, bit e_empty,
                                bit e_full, int e_lvl, bit e_ovf, bit chk_rd, bit [7:0] e_rd);
        vec_t v;
        v.rst = rst; v.wr = wr; v.din = din; v.busy = busy;
        v.e_empty = e_empty; v.e_full = e_full; v.e_lvl = e_lvl; v.e_ovf = e_ovf;
        v.chk_rd = chk_rd; v.e_rd = e_rd;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " empty"}, int'(F_EMPTY), 1);
        chk({tag, " full"}, int'(F_FULL), 0);
        chk({tag, " level"}, int'(FILL_LEVEL), 0);
        chk({tag, " ovf"}, int'(OVF), 0);
        chk({tag, " rd_data"}, int'(RD_DATA), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [7:0] model[$];
        int       next_wr;
        int       pops;
        bit       busy_prev;
        bit       do_pop;
        bit       do_push;

        // Reset then idle.
        RST = 1'b0;
        repeat (2) @(posedge TX_CLK);
        #1;
        chk_reset_vals("reset");
        RST = 1'b1;

        // Single byte, then BUSY held high for 10 cycles gives exactly one pop.
        add(0, 1, 8'hA5, 0, 0, 0, 1, 0, 1, 8'hA5);
        for (int i = 0; i < 10; i++) add(0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 8'h00);
        add(0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00);

        // Fill to DEPTH, overflow, drain in order with OVF sticky.
        for (int i = 1; i <= 8; i++) add(0, 1, 8'(i), 0, 0, (i == 8), i, 0, 1, 8'h01);
        add(0, 1, 8'hFF, 0, 0, 1, 8, 1, 1, 8'h01);
        for (int k = 1; k <= 8; k++) begin
            add(0, 0, 8'h00, 1, (k == 8), 0, 8 - k, 1, (k < 8), 8'(k + 1));
            add(0, 0, 8'h00, 0, (k == 8), 0, 8 - k, 1, (k < 8), 8'(k + 1));
        end

        // Reset clears OVF, then full with simultaneous pop and write.
        add(1, 0, 8'h00, 0, 1, 0, 0, 0, 1, 8'h00);
        for (int i = 1; i <= 8; i++) add(0, 1, 8'(i), 0, 0, (i == 8), i, 0, 1, 8'h01);
        add(0, 1, 8'h09, 1, 0, 1, 8, 0, 1, 8'h02);
        add(0, 0, 8'h00, 0, 0, 1, 8, 0, 1, 8'h02);
        for (int j = 1; j <= 8; j++) begin
            add(0, 0, 8'h00, 1, (j == 8), 0, 8 - j, 0, (j < 8), 8'(2 + j));
            add(0, 0, 8'h00, 0, (j == 8), 0, 8 - j, 0, (j < 8), 8'(2 + j));
        end

        foreach (vecs[i]) begin
            RST     = ~vecs[i].rst;
            WR_EN   = vecs[i].wr;
            WR_DATA = vecs[i].din;
            BUSY    = vecs[i].busy;
            @(posedge TX_CLK);
            #1;
            chk($sformatf("v%0d empty", i), int'(F_EMPTY), int'(vecs[i].e_empty));
            chk($sformatf("v%0d full", i), int'(F_FULL), int'(vecs[i].e_full));
            chk($sformatf("v%0d level", i), int'(FILL_LEVEL), vecs[i].e_lvl);
            chk($sformatf("v%0d ovf", i), int'(OVF), int'(vecs[i].e_ovf));
            if (vecs[i].chk_rd) chk($sformatf("v%0d rd_data", i), int'(RD_DATA), int'(vecs[i].e_rd));
        end
        RST   = 1'b1;
        WR_EN = 1'b0;
        BUSY  = 1'b0;

        // Interleaved writes 8'h10..8'h23 and pops across pointer wrap.
        next_wr   = 0;
        pops      = 0;
        busy_prev = 1'b0;
        for (int cyc = 0; cyc < 200 && pops < 20; cyc++) begin
            WR_EN   = (next_wr < 20) && (cyc % 3 != 2) && (model.size() < 6);
            WR_DATA = 8'(8'h10 + next_wr);
            BUSY    = (cyc % 2 == 1);
            do_pop  = BUSY && !busy_prev && (model.size() != 0);
            do_push = WR_EN;
            @(posedge TX_CLK);
            #1;
            if (do_pop) begin
                void'(model.pop_front());
                pops++;
            end
            if (do_push) begin
                model.push_back(WR_DATA);
                next_wr++;
            end
            busy_prev = BUSY;
            chk($sformatf("wrap c%0d level", cyc), int'(FILL_LEVEL), model.size());
            if (model.size() != 0) chk($sformatf("wrap c%0d rd_data", cyc), int'(RD_DATA), int'(model[0]));
        end
        chk("wrap pop count", pops, 20);
        WR_EN = 1'b0;
        BUSY  = 1'b0;
        @(posedge TX_CLK);
        #1;

        // Async reset between edges with 5 entries held and BUSY high.
        for (int i = 0; i < 6; i++) begin
            WR_EN   = 1'b1;
            WR_DATA = 8'(8'h30 + i);
            @(posedge TX_CLK);
            #1;
        end
        WR_EN = 1'b0;
        BUSY  = 1'b1;
        @(posedge TX_CLK);
        #1;
        chk("pre-reset level", int'(FILL_LEVEL), 5);
        chk("pre-reset rd_data", int'(RD_DATA), 8'h31);
        #2;
        RST = 1'b0;
        #1;
        chk_reset_vals("async reset");
        BUSY = 1'b0;
        @(posedge TX_CLK);
        #1;
        RST = 1'b1;
        WR_EN   = 1'b1;
        WR_DATA = 8'h3C;
        @(posedge TX_CLK);
        #1;
        WR_EN = 1'b0;
        chk("post-reset rd_data", int'(RD_DATA), 8'h3C);
        chk("post-reset level", int'(FILL_LEVEL), 1);
        chk("post-reset empty", int'(F_EMPTY), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
